// File: rtl/mux8_ser_sequencer_if.sv
// mux8_ser_sequencer_if
//   Bundles the parallel load handshake, the mux drive/return signals and
//   the serial output handshake of mux8_ser_sequencer.
//   load_*  : parallel word source -> sequencer (valid/ready)
//   i, s    : sequencer -> 8:1 mux data inputs / select
//   mux_out : 8:1 mux output -> sequencer
//   ser_*   : sequencer -> serial consumer (valid/ready/last)
//   busy    : word in progress
//   Modport slave is the sequencer view; master is the surrounding system.
interface mux8_ser_sequencer_if;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [7:0] i;
    logic [2:0] s;
    logic       mux_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_data;
    logic       ser_last;
    logic       busy;

    modport slave (
        input  load_valid, load_data, mux_out, ser_ready,
        output load_ready, i, s, ser_valid, ser_data, ser_last, busy
    );

    modport master (
        output load_valid, load_data, mux_out, ser_ready,
        input  load_ready, i, s, ser_valid, ser_data, ser_last, busy
    );
endinterface

// File: rtl/mux8_ser_sequencer.sv
// mux8_ser_sequencer
//   Holds an accepted 8-bit word on the mux data inputs and walks the mux
//   select through all eight positions, forwarding the mux output as a
//   serial valid/ready/last stream. A new word can be taken on the last
//   beat so consecutive words stream without a bubble.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : mux8_ser_sequencer_if.slave (load, mux and serial signals)
// Parameters:
//   MSB_FIRST : 0 -> select 0..7, 1 -> select 7..0
module mux8_ser_sequencer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    mux8_ser_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [2:0] S_START = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state, state_nxt;
    logic [7:0] word_q, word_nxt;
    logic [2:0] sel_q, sel_nxt;
    logic [2:0] cnt_q, cnt_nxt;
    logic       load_ready_c, ser_valid_c, ser_last_c, busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            word_q <= 8'h00;
            sel_q  <= 3'd0;
            cnt_q  <= 3'd0;
        end else begin
            state  <= state_nxt;
            word_q <= word_nxt;
            sel_q  <= sel_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_nxt     = word_q;
        sel_nxt      = sel_q;
        cnt_nxt      = cnt_q;
        load_ready_c = 1'b0;
        ser_valid_c  = 1'b0;
        ser_last_c   = 1'b0;
        busy_c       = 1'b0;
        case (state)
            IDLE: begin
                load_ready_c = 1'b1;
                if (bus.load_valid) begin
                    word_nxt  = bus.load_data;
                    cnt_nxt   = 3'd0;
                    sel_nxt   = S_START;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid_c = 1'b1;
                busy_c      = 1'b1;
                ser_last_c  = (cnt_q == 3'd7);
                if (bus.ser_ready) begin
                    if (cnt_q != 3'd7) begin
                        cnt_nxt = cnt_q + 3'd1;
                        sel_nxt = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
                    end else begin
                        // Last beat consumed: hand off to the next word in
                        // the same cycle if one is waiting.
                        load_ready_c = 1'b1;
                        if (bus.load_valid) begin
                            word_nxt = bus.load_data;
                            cnt_nxt  = 3'd0;
                            sel_nxt  = S_START;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Outputs are forced quiet for the whole reset cycle; the register
        // reset overrides whatever next-state was computed above.
        if (rst) begin
            load_ready_c = 1'b0;
            ser_valid_c  = 1'b0;
            ser_last_c   = 1'b0;
            busy_c       = 1'b0;
        end
    end

    assign bus.load_ready = load_ready_c;
    assign bus.ser_valid  = ser_valid_c;
    assign bus.ser_last   = ser_last_c;
    assign bus.busy       = busy_c;
    assign bus.i          = word_q;
    assign bus.s          = sel_q;
    assign bus.ser_data   = bus.mux_out;
endmodule

// File: tb/tb_mux8_ser_sequencer.sv
module tb_mux8_ser_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       lv, sr;
    logic [7:0] ld;
    int         n_chk = 0;
    int         n_err = 0;

    // Reference model: the word being sent, which beat of it is on the
    // wire, and the select each variant is expected to hold.
    bit         m_act;
    logic [7:0] m_word;
    int         m_beat;
    logic [2:0] m_s0, m_s1;
    int         vcount;

    always #5 clk = ~clk;

    mux8_ser_sequencer_if b0 ();
    mux8_ser_sequencer_if b1 ();

    assign b0.load_valid = lv;
    assign b0.load_data  = ld;
    assign b0.ser_ready  = sr;
    assign b1.load_valid = lv;
    assign b1.load_data  = ld;
    assign b1.ser_ready  = sr;
    // Behavioural 8:1 mux between each DUT's i/s and its mux_out.
    assign b0.mux_out = b0.i[b0.s];
    assign b1.mux_out = b1.i[b1.s];

    mux8_ser_sequencer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mux8_ser_sequencer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check both DUTs mid-cycle, advance the model.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d, input logic rdy);
        logic exp_lr, exp_vld, exp_last;
        rst = r; lv = v; ld = d; sr = rdy;
        @(negedge clk);
        exp_lr   = !r && (!m_act || (m_beat == 7 && rdy));
        exp_vld  = !r && m_act;
        exp_last = !r && m_act && (m_beat == 7);
        if (b0.ser_valid) vcount++;
        chk("lr0",   {31'd0, b0.load_ready}, {31'd0, exp_lr});
        chk("lr1",   {31'd0, b1.load_ready}, {31'd0, exp_lr});
        chk("vld0",  {31'd0, b0.ser_valid},  {31'd0, exp_vld});
        chk("vld1",  {31'd0, b1.ser_valid},  {31'd0, exp_vld});
        chk("busy0", {31'd0, b0.busy},       {31'd0, exp_vld});
        chk("last0", {31'd0, b0.ser_last},   {31'd0, exp_last});
        chk("last1", {31'd0, b1.ser_last},   {31'd0, exp_last});
        chk("i0",    {24'd0, b0.i},          {24'd0, m_word});
        chk("i1",    {24'd0, b1.i},          {24'd0, m_word});
        chk("s0",    {29'd0, b0.s},          {29'd0, m_s0});
        chk("s1",    {29'd0, b1.s},          {29'd0, m_s1});
        if (exp_vld) begin
            chk("dat0", {31'd0, b0.ser_data}, {31'd0, m_word[m_beat]});
            chk("dat1", {31'd0, b1.ser_data}, {31'd0, m_word[7 - m_beat]});
        end
        if (r) begin
            m_act = 0; m_word = 8'h00; m_beat = 0; m_s0 = 3'd0; m_s1 = 3'd0;
        end else if (exp_lr && v) begin
            m_act = 1; m_word = d; m_beat = 0; m_s0 = 3'd0; m_s1 = 3'd7;
        end else if (m_act && rdy) begin
            if (m_beat < 7) begin
                m_beat++;
                m_s0 = 3'(m_beat);
                m_s1 = 3'(7 - m_beat);
            end else begin
                m_act = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic bp [14];
        bp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b1; lv = 1'b0; ld = 8'h00; sr = 1'b0;
        m_act = 0; m_word = 8'h00; m_beat = 0; m_s0 = 3'd0; m_s1 = 3'd0;
        @(posedge clk); #1;

        // Reset, then single words A5 and 81 at full throughput.
        cycle(1, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 1);
        cycle(0, 1, 8'hA5, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'h81, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 8'h00, 1);

        // Backpressure on beats 2 and 5: 14 valid cycles for one word.
        cycle(0, 1, 8'h3C, 1);
        vcount = 0;
        for (int k = 0; k < 14; k++) cycle(0, 0, 8'h00, bp[k]);
        cycle(0, 0, 8'h00, 1);
        chk("bp_valid_cycles", 32'(vcount), 32'd14);

        // Back-to-back FF then 00; the 00 is refused until the last beat.
        cycle(0, 1, 8'hFF, 1);
        for (int k = 0; k < 7; k++) cycle(0, 1, (k < 4) ? 8'hFF : 8'h55, 1);
        vcount = 0;
        cycle(0, 1, 8'h00, 1);
        for (int k = 0; k < 8; k++) cycle(0, 0, 8'h00, 1);
        chk("b2b_valid_cycles", 32'(vcount), 32'd9);
        cycle(0, 0, 8'h00, 1);

        // Reset mid-word, then a clean reload.
        cycle(0, 1, 8'hF0, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'h00, 1);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'h0F, 1);
        for (int k = 0; k < 10; k++) cycle(0, 0, 8'h00, 1);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 4000; k++)
            cycle(($urandom_range(99) == 0), ($urandom_range(2) == 0),
                  8'($urandom), ($urandom_range(3) != 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mux8_ser_sequencer.md
Name: mux8_ser_sequencer

Overview:
- Control stage that drives the team's 8:1 mux.
- Accepts an 8-bit parallel word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the 3-bit select through all eight positions and forwards the mux output as a serial bit stream with valid/ready/last.
- Sits between the parallel word source and the serial consumer; the mux sits combinationally between this block's `i`/`s` outputs and its `mux_out` input.

Parameters:
- MSB_FIRST, 0, 0: select order 0→7 (bit 0 first); 1: select order 7→0 (bit 7 first).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  parallel word available
- load_ready  output  1  block can accept a word this cycle
- load_data  input  8  parallel word
- i  output  8  registered word, wired to the mux data inputs
- s  output  3  registered select, wired to the mux select
- mux_out  input  1  mux output
- ser_valid  output  1  ser_data is valid
- ser_ready  input  1  consumer accepts the bit
- ser_data  output  1  serial bit (combinational pass-through of mux_out)
- ser_last  output  1  current bit is the 8th of the word
- busy  output  1  word in progress (state == SHIFT)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clock edge): state=IDLE, i=8'h00, s=3'd0, cnt=3'd0.
  - While rst is high: load_ready=0, ser_valid=0, ser_last=0, busy=0.
  - Reset mid-word aborts the word; no further ser_valid until a new load.
- State IDLE:
  - load_ready=1, ser_valid=0, busy=0.
  - On load_valid&&load_ready: i<=load_data, cnt<=0, s<=start select (0, or 7 if MSB_FIRST), next state SHIFT.
- State SHIFT:
  - ser_valid=1, busy=1, ser_data=mux_out, ser_last=(cnt==7).
  - Select mapping: s = cnt when MSB_FIRST=0; s = 7−cnt when MSB_FIRST=1. s is a registered copy of that value.
  - On ser_valid&&ser_ready with cnt<7: cnt<=cnt+1 and s advances one position (+1, or −1 if MSB_FIRST).
  - On ser_valid&&ser_ready with cnt==7 (last beat):
    - If load_valid is also high: accept the new word in the same cycle (i<=load_data, cnt<=0, s<=start) and stay in SHIFT. This gives back-to-back words with no bubble.
    - Otherwise: go to IDLE; i holds its value, s holds 7 (or 0).
- load_ready = !rst && (IDLE || (SHIFT && cnt==7 && ser_ready)).
  - Combinational; the only combinational path from ser_ready to an output.
- Backpressure: while ser_valid&&!ser_ready, cnt, s and i are frozen, so ser_data is stable. Loads are refused except at the last-beat handoff above.
- Latency: load accepted at edge N → first bit valid in cycle N+1. A word takes 8 accepted beats minimum. Throughput is 1 bit/cycle with ser_ready held high, including across words.
- Counter wraps only through reload; cnt never increments past 7.
- Bit order: beat k (0..7) carries load_data[k], or load_data[7−k] if MSB_FIRST.
- No X propagation: i, s and cnt are always reset and always assigned.

Test Plan:
- Reset then single load: rst high for 2 cycles, then load 8'hA5 with ser_ready=1.
  - Expect load_ready=0 during reset and 1 after.
  - Serial stream 1,0,1,0,0,1,0,1 on consecutive cycles; s=0..7; ser_last only on beat 8.
  - Then IDLE with busy=0.
- MSB_FIRST=1, load 8'h81:
  - Expect stream 1,0,0,0,0,0,0,1 with s=7,6,...,0.
- Backpressure: load 8'h3C; drop ser_ready on beats 2 and 5 for 3 cycles each.
  - Expect s and ser_data frozen while stalled.
  - Total 14 cycles of ser_valid; stream 0,0,1,1,1,1,0,0.
- Back-to-back: hold load_valid high with 8'hFF then 8'h00, ser_ready=1.
  - Expect load_ready pulse in the ser_last cycle and no bubble.
  - 16 consecutive valid beats: eight 1s then eight 0s.
- Reset mid-word: load 8'hF0; assert rst at beat 3.
  - Expect ser_valid=0, s=0, i=0 next cycle.
  - A subsequent load of 8'h0F streams cleanly from beat 0.
- Load while busy: present load_valid mid-word (beat 4).
  - Expect load_ready=0 and the word ignored until the last-beat handoff.
